// File: rtl/phase_monitor_pkg.sv
// Shared encodings for the four-phase clock monitor: phase codes, error codes,
// FSM states and the small decode helpers used by the monitor and its schedule.
package phase_monitor_pkg;

    localparam logic [2:0] PH_GAP = 3'd0;
    localparam logic [2:0] PH_B   = 3'd1;
    localparam logic [2:0] PH_C   = 3'd2;
    localparam logic [2:0] PH_D   = 3'd3;
    localparam logic [2:0] PH_A   = 3'd4;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_OVERLAP  = 3'd1;
    localparam logic [2:0] ERR_MISSING  = 3'd2;
    localparam logic [2:0] ERR_SPURIOUS = 3'd3;
    localparam logic [2:0] ERR_WRONG    = 3'd4;

    // Sample vector bit order is {A, B, C, D}
    localparam logic [3:0] VEC_B = 4'b0100;

    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    function automatic logic [3:0] phase_vec(input logic [2:0] ph);
        case (ph)
            PH_B:    return 4'b0100;
            PH_C:    return 4'b0010;
            PH_D:    return 4'b0001;
            PH_A:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] classify_err(input logic [3:0] s, input logic [3:0] e);
        logic [2:0] ones;
        ones = {2'b00, s[0]} + {2'b00, s[1]} + {2'b00, s[2]} + {2'b00, s[3]};
        if (s == e)
            return ERR_NONE;
        else if (ones > 3'd1)
            return ERR_OVERLAP;
        else if (s == 4'b0000)
            return ERR_MISSING;
        else if (e == 4'b0000)
            return ERR_SPURIOUS;
        else
            return ERR_WRONG;
    endfunction

endpackage

// File: rtl/phase_schedule.sv
// Maps the frame position t to the expected phase-line vector and phase code:
// B, C, D, A pulses of PULSE_W cycles spaced by GAP_W low cycles, idle afterwards.
module phase_schedule
    import phase_monitor_pkg::*;
#(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 4,
    parameter int unsigned PERIOD  = 64
) (
    input  logic [$clog2(PERIOD)-1:0] t,
    output logic [3:0]                exp_vec,
    output logic [2:0]                exp_ph
);

    localparam int unsigned STRIDE = PULSE_W + GAP_W;

    always_comb begin
        exp_ph = PH_GAP;
        for (int unsigned k = 0; k < 4; k++) begin
            if ((32'(t) >= k * STRIDE) && (32'(t) < k * STRIDE + PULSE_W))
                exp_ph = 3'(k + 1);
        end
        exp_vec = phase_vec(exp_ph);
    end

endmodule

// File: rtl/phase_monitor.sv
// Receive-side checker for the four-phase clock set: aligns to the B rise,
// tracks the frame schedule, classifies sequence errors and reports lock.
module phase_monitor
    import phase_monitor_pkg::*;
#(
    parameter int unsigned PULSE_W     = 4,
    parameter int unsigned GAP_W       = 4,
    parameter int unsigned PERIOD      = 64,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        clkA,
    input  logic        clkB,
    input  logic        clkC,
    input  logic        clkD,
    output logic [2:0]  phase,
    output logic        frame_done,
    output logic        locked,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] frame_cnt
);

    localparam int unsigned TW = $clog2(PERIOD);
    localparam int unsigned RW = $clog2(LOCK_FRAMES + 1);
    localparam logic [TW-1:0] T_LAST  = TW'(PERIOD - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(LOCK_FRAMES);

    state_t        state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic          b_prev_q, b_prev_d;
    logic [1:0]    warm_q, warm_d;
    logic [TW-1:0] t_q, t_d;
    logic [2:0]    phase_q, phase_d;
    logic          frame_done_q, frame_done_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic [2:0]    err_code_q, err_code_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [RW-1:0] run_q, run_d;

    logic [3:0]    exp_vec;
    logic [2:0]    exp_ph;
    logic [2:0]    code;
    logic [RW-1:0] run_inc;

    phase_schedule #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W),
        .PERIOD  (PERIOD)
    ) u_sched (
        .t       (t_q),
        .exp_vec (exp_vec),
        .exp_ph  (exp_ph)
    );

    always_comb begin
        s_d          = {clkA, clkB, clkC, clkD};
        b_prev_d     = s_q[2];
        // warm_q[1] means both s_q and b_prev_q hold post-reset samples, so a B
        // already high at reset release is never mistaken for a rising edge.
        warm_d       = {warm_q[0], 1'b1};
        state_d      = state_q;
        t_d          = t_q;
        phase_d      = phase_q;
        frame_done_d = 1'b0;
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_code_d   = err_code_q;
        frame_cnt_d  = frame_cnt_q;
        run_d        = run_q;
        code         = classify_err(s_q, exp_vec);
        run_inc      = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;

        case (state_q)
            ST_HUNT: begin
                phase_d = PH_GAP;
                if (warm_q[1] && (s_q == VEC_B) && !b_prev_q) begin
                    state_d = ST_TRACK;
                    t_d     = TW'(1);
                    phase_d = PH_B;
                end
            end
            ST_TRACK: begin
                if (code != ERR_NONE) begin
                    state_d    = ST_HUNT;
                    t_d        = '0;
                    phase_d    = PH_GAP;
                    err_d      = 1'b1;
                    err_code_d = code;
                    locked_d   = 1'b0;
                    run_d      = '0;
                end else begin
                    phase_d = exp_ph;
                    if (t_q == T_LAST) begin
                        t_d          = '0;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        run_d        = run_inc;
                        locked_d     = (run_inc == RUN_MAX);
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            s_q          <= '0;
            b_prev_q     <= 1'b0;
            warm_q       <= '0;
            t_q          <= '0;
            phase_q      <= PH_GAP;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            frame_cnt_q  <= '0;
            run_q        <= '0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            b_prev_q     <= b_prev_d;
            warm_q       <= warm_d;
            t_q          <= t_d;
            phase_q      <= phase_d;
            frame_done_q <= frame_done_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            frame_cnt_q  <= frame_cnt_d;
            run_q        <= run_d;
        end
    end

    assign phase      = phase_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_phase_monitor.sv
// Bench for phase_monitor: directed fault frames plus randomized bit flips,
// checked every cycle against a frame-level reference model.
module tb_phase_monitor;

    localparam int PW    = 4;
    localparam int GW    = 4;
    localparam int PER   = 64;
    localparam int LOCKF = 2;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        clkA = 1'b0, clkB = 1'b0, clkC = 1'b0, clkD = 1'b0;
    logic [2:0]  phase;
    logic        frame_done, locked, err;
    logic [2:0]  err_code;
    logic [15:0] frame_cnt;

    always #5 clk_in = ~clk_in;

    phase_monitor #(
        .PULSE_W     (PW),
        .GAP_W       (GW),
        .PERIOD      (PER),
        .LOCK_FRAMES (LOCKF)
    ) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .clkA       (clkA),
        .clkB       (clkB),
        .clkC       (clkC),
        .clkD       (clkD),
        .phase      (phase),
        .frame_done (frame_done),
        .locked     (locked),
        .err        (err),
        .err_code   (err_code),
        .frame_cnt  (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Phase code (0 gap, 1 B, 2 C, 3 D, 4 A) at frame position t
    function automatic int sched_ph(input int t);
        int slot, off;
        slot = t / (PW + GW);
        off  = t % (PW + GW);
        return (slot < 4 && off < PW) ? slot + 1 : 0;
    endfunction

    function automatic logic [3:0] ph_to_vec(input int ph);
        case (ph)
            1:       return 4'b0100;
            2:       return 4'b0010;
            3:       return 4'b0001;
            4:       return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Reference model state
    logic [3:0] m_s = '0;
    logic [3:0] m_ev;
    bit   m_pb = 0, m_trk = 0;
    int   m_warm = 0, m_t = 0, m_eph = 0;
    int   m_ph = 0, m_fd = 0, m_lk = 0, m_err = 0, m_code = 0, m_cnt = 0, m_run = 0;

    always @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            m_s = '0; m_pb = 0; m_warm = 0; m_trk = 0; m_t = 0;
            m_ph = 0; m_fd = 0; m_lk = 0; m_err = 0; m_code = 0; m_cnt = 0; m_run = 0;
        end else begin
            m_fd  = 0;
            m_err = 0;
            if (!m_trk) begin
                m_ph = 0;
                if (m_warm >= 2 && m_s == 4'b0100 && !m_pb) begin
                    m_trk = 1; m_t = 1; m_ph = 1;
                end
            end else begin
                m_eph = sched_ph(m_t);
                m_ev  = ph_to_vec(m_eph);
                if (m_s != m_ev) begin
                    m_err = 1; m_trk = 0; m_ph = 0; m_lk = 0; m_run = 0; m_t = 0;
                    if ($countones(m_s) > 1)  m_code = 1;
                    else if (m_s == 4'b0000)  m_code = 2;
                    else if (m_ev == 4'b0000) m_code = 3;
                    else                      m_code = 4;
                end else begin
                    m_ph = m_eph;
                    if (m_t == PER - 1) begin
                        m_t   = 0;
                        m_fd  = 1;
                        m_cnt = (m_cnt + 1) % 65536;
                        if (m_run < LOCKF) m_run++;
                        m_lk  = (m_run == LOCKF) ? 1 : 0;
                    end else begin
                        m_t++;
                    end
                end
            end
            m_pb = m_s[2];
            m_s  = {clkA, clkB, clkC, clkD};
            if (m_warm < 2) m_warm++;
        end
    end

    // Stimulus bookkeeping
    int cyc = 0;
    int t_hist[int];
    int g_fault = 0, g_ft = 0, g_fbit = 0;
    bit cmp_en = 0;

    int fd_seen = 0, err_seen = 0, last_code = 0, last_err_t = -99, cnt_at_lock = -1;
    bit lk_prev = 0;

    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("phase",      phase,      m_ph);
            check("frame_done", frame_done, m_fd);
            check("locked",     locked,     m_lk);
            check("err",        err,        m_err);
            check("err_code",   err_code,   m_code);
            check("frame_cnt",  frame_cnt,  m_cnt);
            if (frame_done) fd_seen++;
            if (err) begin
                err_seen++;
                last_code  = err_code;
                last_err_t = t_hist.exists(cyc - 2) ? t_hist[cyc - 2] : -1;
            end
            if (locked && !lk_prev && cnt_at_lock < 0) cnt_at_lock = frame_cnt;
            lk_prev = locked;
        end
    end

    // Generator: nominal waveform with an optional fault for the current frame
    function automatic logic [3:0] gen_vec(input int t);
        int ph;
        logic [3:0] v;
        ph = sched_ph(t);
        if (g_fault == 4 && ph == 2)      ph = 3;
        else if (g_fault == 4 && ph == 3) ph = 2;
        if (g_fault == 3 && ph == 4)      ph = 0;
        v = ph_to_vec(ph);
        if (g_fault == 1 && t == 2 * PW + GW) v[1] = 1'b1;
        if (g_fault == 2 && t == PW + GW)     v[0] = 1'b1;
        if (g_fault == 5 && t == g_ft)        v[g_fbit] = ~v[g_fbit];
        return v;
    endfunction

    task automatic drive_cycle(input logic [3:0] v, input logic rst, input int t);
        @(posedge clk_in);
        #2;
        {clkA, clkB, clkC, clkD} = v;
        reset_n = rst;
        cyc++;
        t_hist[cyc] = t;
    endtask

    task automatic run_frame(input int from, input int to);
        for (int t = from; t < to; t++) drive_cycle(gen_vec(t), 1'b1, t);
    endtask

    task automatic sync();
        @(negedge clk_in);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},      phase,      0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_locked"},     locked,     0);
        check({tag, "_err"},        err,        0);
        check({tag, "_err_code"},   err_code,   0);
        check({tag, "_frame_cnt"},  frame_cnt,  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        drive_cycle(4'b0000, 1'b0, -1);
        cmp_en = 1;
        drive_cycle(4'b0000, 1'b0, -1);
        sync();
        check_all_zero("reset");
        repeat (3) drive_cycle(4'b0000, 1'b1, -1);

        // Five nominal frames: lock after the second, count reaches five
        g_fault = 0;
        repeat (5) run_frame(0, PER);
        run_frame(0, 2);
        sync();
        check("nominal_frame_cnt", frame_cnt, 5);
        check("nominal_locked", locked, 1);
        check("nominal_fd_pulses", fd_seen, 5);
        check("nominal_no_err", err_seen, 0);
        check("cnt_when_locked", cnt_at_lock, 2);
        run_frame(2, PER);

        // C held one cycle too long
        g_fault = 1;
        run_frame(0, PER);
        sync();
        check("spurious_code", last_code, 3);
        check("spurious_t", last_err_t, 12);
        check("spurious_unlocked", locked, 0);
        check("spurious_no_fd", fd_seen, 6);
        check("spurious_frame_cnt", frame_cnt, 6);

        g_fault = 0;
        repeat (2) run_frame(0, PER);
        g_fault = 2;
        run_frame(0, 2);
        sync();
        check("relock_locked", locked, 1);
        check("relock_frame_cnt", frame_cnt, 8);
        run_frame(2, PER);
        sync();
        check("overlap_code", last_code, 1);
        check("overlap_t", last_err_t, 8);

        g_fault = 3;
        run_frame(0, PER);
        sync();
        check("missing_code", last_code, 2);
        check("missing_t", last_err_t, 24);

        g_fault = 0;
        run_frame(0, 3);
        sync();
        check("retrack_phase_b", phase, 1);
        run_frame(3, PER);

        g_fault = 4;
        run_frame(0, PER);
        sync();
        check("wrong_code", last_code, 4);
        check("wrong_t", last_err_t, 8);

        // Reset mid-frame at t = 30 for three cycles
        g_fault = 0;
        repeat (2) run_frame(0, PER);
        run_frame(0, 30);
        drive_cycle(gen_vec(30), 1'b0, 30);
        #1;
        check_all_zero("midreset");
        drive_cycle(gen_vec(31), 1'b0, 31);
        drive_cycle(gen_vec(32), 1'b0, 32);
        run_frame(33, PER);
        run_frame(0, PER);
        run_frame(0, 2);
        sync();
        check("post_reset_frame_cnt", frame_cnt, 1);
        check("post_reset_locked", locked, 0);
        run_frame(2, PER);

        // Randomized faults, checked only by the per-cycle model comparison
        repeat (24) begin
            r = $urandom_range(0, 9);
            if (r < 4)      g_fault = 0;
            else if (r < 9) g_fault = 5;
            else            g_fault = $urandom_range(1, 4);
            g_ft   = $urandom_range(0, PER - 1);
            g_fbit = $urandom_range(0, 3);
            run_frame(0, PER);
        end

        // B already high when reset releases must not start tracking
        g_fault = 0;
        drive_cycle(gen_vec(0), 1'b0, 0);
        drive_cycle(gen_vec(1), 1'b0, 1);
        run_frame(2, 11);
        sync();
        check("bhigh_still_hunting", phase, 0);
        check("bhigh_frame_cnt", frame_cnt, 0);
        run_frame(11, PER);
        repeat (2) run_frame(0, PER);
        run_frame(0, 2);
        sync();
        check("bhigh_next_frames_cnt", frame_cnt, 2);
        check("bhigh_next_frames_locked", locked, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
